fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

Round-robin read scheduler that shares one downstream consumer between NUM_SRC `fifo` instances. Each cycle it picks one non-empty, enabled source, pulses that FIFO's `ren`, and presents the returned word on a valid/ready output together with the source index. It sits between the per-requester task FIFOs and the single shared solver input. It sustains one word per cycle when the consumer is always ready.

## Interface
- NUM_SRC, 4: number of source FIFOs (2..16).
- WIDTH, 40: data width; matches the FIFO `width`.
- ADDR_BITS, 3: FIFO `addr_bits`; each count is ADDR_BITS+1 bits wide.
- SRC_BITS, $clog2(NUM_SRC): width of the source index.

- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- src_enable  in  NUM_SRC  per-source grant mask; a source with bit 0 is never selected.
- src_count  in  NUM_SRC*(ADDR_BITS+1)  FIFO `count` outputs; source i is slice i.
- src_rdata  in  NUM_SRC*WIDTH  FIFO `rdata` outputs; source i is slice i.
- src_ren  out  NUM_SRC  read strobes to the FIFOs; one-hot or zero.
- out_valid  out  1  out_data and out_src hold a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WIDTH  the src_rdata slice selected by out_src.
- out_src  out  SRC_BITS  index of the FIFO that supplied out_data.
- busy  out  1  out_valid is high, or any enabled source has a nonzero count.

## Operation
- Source i is eligible when src_enable[i]=1 and src_count[i]!=0. The FIFO write-bypass path (count==0 with a simultaneous write) is never used: the arbiter never reads an empty FIFO.
- Registered state:
  - `pend`: drives out_valid.
  - `sel` (SRC_BITS): drives out_src.
  - `ptr` (SRC_BITS): round-robin priority pointer.
- Issue condition: `issue = any_eligible && (!pend || out_ready)`. It is evaluated combinationally, so src_ren depends combinationally on out_ready.
- Grant selection: the first eligible index scanning ptr, ptr+1, …, NUM_SRC-1, 0, …, ptr-1 (modulo NUM_SRC).
- When issue=1:
  - src_ren[g]=1 for the granted index g; all other bits are 0.
  - Next edge: pend<=1, sel<=g, ptr<=(g+1) mod NUM_SRC. The wrap is explicit: g=NUM_SRC-1 gives ptr=0.
- When issue=0 and pend && out_ready: pend<=0; sel and ptr hold.
- When issue=0 and !(pend && out_ready): all state holds.
- out_data is src_rdata[sel]. This is valid because each FIFO holds rdata until its next ren, and the arbiter only re-reads a source after its pending word has been consumed.
- Effect of src_enable:
  - A source is removed from arbitration on the cycle its enable bit drops.
  - A word already pending from that source is still delivered.
- Reset values: pend=0, sel=0, ptr=0, so out_valid=0 and out_src=0; src_ren=0 during reset. out_data follows src_rdata slice 0 after reset and is don't-care while out_valid=0. Reset mid-transfer drops any pending word; the FIFOs are reset by the same reset.

## Timing
- Read latency: src_ren high in cycle t gives out_valid=1 with FIFO data in cycle t+1.
- Throughput: with out_ready held at 1 and sources eligible, one grant and one word per cycle.
- Hand-off: the word is consumed in the same cycle the next grant's ren fires. The new word is visible in the next cycle with no bubble.
- Backpressure: pend && !out_ready gives src_ren=0. out_data and out_src hold stable until accepted.
- Count freshness: src_count updates on the same edge as the ren it reflects. A source at count=1 granted in cycle t is ineligible in cycle t+1 unless it was also written in cycle t.
- No eligible source:
  - A pending word drains normally; out_valid falls the cycle after acceptance.
  - ptr holds while no grant is made.
- busy is combinational from the current state and inputs.

## Test plan
- **Reset:** assert reset for 2 cycles with all counts at 3. Required: src_ren=0, out_valid=0, out_src=0 during reset; the first grant is src 0 in the first cycle after reset.
- **Round-robin fairness:** all 4 sources enabled with counts {2,2,2,2}, out_ready=1. Required:
  - grants 0,1,2,3,0,1,2,3 on 8 consecutive cycles;
  - out_src sequence lagging by one cycle;
  - out_valid falls after the 8th word.
- **Backpressure:** one word pending from src 2, out_ready=0 for 5 cycles. Required:
  - src_ren=0 throughout;
  - out_data and out_src=2 stable throughout;
  - when out_ready rises, the next grant's ren fires in that same cycle.
- **Wrap and skip:** ptr=3, only src 1 eligible. Required: the grant goes to src 1 and ptr becomes 2. Then with src 3 and src 0 eligible and ptr=3: src 3 is granted, then src 0.
- **Enable mask and count edge:** src 0 has count=1 and src_enable=4'b0001. Required: exactly one grant, then no further ren. Then clear src_enable[0] while a word is pending; required: that word is still delivered with out_src=0.
- **Mid-operation reset:** assert reset while out_valid=1 and out_ready=0. Required: out_valid=0 on the next edge; ptr=0 after reset.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin read scheduler sharing one valid/ready consumer
// between NUM_SRC task FIFOs. One FIFO read strobe per cycle at most; the word
// returned by the FIFO is presented on the output the following cycle.
module fifo_rr_arbiter #(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned WIDTH     = 40,
   parameter int unsigned ADDR_BITS = 3,
   parameter int unsigned SRC_BITS  = $clog2(NUM_SRC)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_SRC-1:0]             src_enable,
   input  logic [NUM_SRC*(ADDR_BITS+1)-1:0] src_count,
   input  logic [NUM_SRC*WIDTH-1:0]       src_rdata,
   output logic [NUM_SRC-1:0]             src_ren,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out_data,
   output logic [SRC_BITS-1:0]            out_src,
   output logic                           busy
);

   localparam int unsigned CNT_W = ADDR_BITS + 1;
   // One extra bit so ptr + offset can exceed NUM_SRC-1 before the wrap.
   localparam int unsigned IDX_W = SRC_BITS + 1;

   logic                pend_q, pend_d;
   logic [SRC_BITS-1:0] sel_q,  sel_d;
   logic [SRC_BITS-1:0] ptr_q,  ptr_d;

   logic [NUM_SRC-1:0]  elig;
   logic                any_elig;
   logic [SRC_BITS-1:0] grant_idx;
   logic                grant_found;
   logic [IDX_W-1:0]    cand;
   logic                issue;
   logic [NUM_SRC-1:0]  ren_c;
   logic [WIDTH-1:0]    data_c;

   // Eligibility: enabled and holding at least one word (never read an empty FIFO).
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         elig[i] = src_enable[i] && (src_count[i*CNT_W +: CNT_W] != '0);
      end
   end

   assign any_elig = |elig;

   // Rotating priority scan: first eligible index starting at ptr, wrapping at NUM_SRC.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = {1'b0, ptr_q} + IDX_W'(k);
         if (cand >= IDX_W'(NUM_SRC)) begin
            cand = cand - IDX_W'(NUM_SRC);
         end
         if (!grant_found && elig[cand[SRC_BITS-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[SRC_BITS-1:0];
         end
      end
   end

   // A new read may issue when the output slot is empty or is being emptied now.
   assign issue = any_elig && (!pend_q || out_ready);

   // One-hot read strobe for the granted FIFO; held low while in reset.
   always_comb begin
      ren_c = '0;
      if (issue && !reset) begin
         ren_c[grant_idx] = 1'b1;
      end
   end

   assign src_ren = ren_c;

   // Next-state: load a new grant, drain an accepted word, or hold.
   always_comb begin
      pend_d = pend_q;
      sel_d  = sel_q;
      ptr_d  = ptr_q;
      if (issue) begin
         pend_d = 1'b1;
         sel_d  = grant_idx;
         if (grant_idx == SRC_BITS'(NUM_SRC - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx + SRC_BITS'(1);
         end
      end else if (pend_q && out_ready) begin
         pend_d = 1'b0;
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q <= 1'b0;
         sel_q  <= '0;
         ptr_q  <= '0;
      end else begin
         pend_q <= pend_d;
         sel_q  <= sel_d;
         ptr_q  <= ptr_d;
      end
   end

   // Output word comes straight from the selected FIFO, which holds rdata until its next read.
   always_comb begin
      data_c = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel_q == SRC_BITS'(i)) begin
            data_c = src_rdata[i*WIDTH +: WIDTH];
         end
      end
   end

   assign out_data  = data_c;
   assign out_valid = pend_q;
   assign out_src   = sel_q;
   assign busy      = pend_q || any_elig;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: emulated source FIFOs, a directed
// vector table, hand-written corner sequences and a randomized run against
// an arithmetic reference model.
module tb_fifo_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 40;
   localparam int AB = 3;
   localparam int CW = AB + 1;
   localparam int SB = 2;
   localparam int DEPTH = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic [N-1:0]  src_enable;
   logic [N*CW-1:0] src_count;
   logic [N*W-1:0]  src_rdata;
   logic [N-1:0]  src_ren;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [SB-1:0] out_src;
   logic          busy;

   fifo_rr_arbiter #(.NUM_SRC(N), .WIDTH(W), .ADDR_BITS(AB)) dut (
      .clock      (clock),
      .reset      (reset),
      .src_enable (src_enable),
      .src_count  (src_count),
      .src_rdata  (src_rdata),
      .src_ren    (src_ren),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_src    (out_src),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // Emulated source FIFOs
   logic [W-1:0] fq [N][$];
   logic [W-1:0] rd [N];
   int           seq = 0;

   // Reference model state
   bit           m_pend;
   int           m_sel;
   int           m_ptr;
   logic [W-1:0] m_word;

   // Last observed outputs
   logic [N-1:0]  o_ren;
   logic          o_valid;
   logic [SB-1:0] o_src;
   logic [W-1:0]  o_data;
   logic          o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [N-1:0]  en;
      logic          rdy;
      logic [N-1:0]  exp_ren;
      logic          exp_valid;
      logic [SB-1:0] exp_src;
      logic          exp_busy;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_env();
      for (int i = 0; i < N; i++) begin
         src_count[i*CW +: CW] = CW'(fq[i].size());
         src_rdata[i*W +: W]   = rd[i];
      end
   endtask

   task automatic load(input int s, input int n);
      for (int k = 0; k < n; k++) begin
         if (fq[s].size() < DEPTH) begin
            fq[s].push_back({8'(s), 32'(seq)});
            seq++;
         end
      end
      drive_env();
   endtask

   // One clock: apply inputs, compare against the model before the edge, then
   // let the emulated FIFOs react to the observed read strobes and pushes.
   task automatic cycle(input logic [N-1:0] en, input logic rdy, input logic rst,
                        input logic [N-1:0] push);
      int  g;
      bit  iss;
      bit  any;
      logic [N-1:0] exp_ren;
      src_enable = en;
      out_ready  = rdy;
      reset      = rst;
      drive_env();
      @(negedge clock);
      g   = -1;
      any = 0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (en[j] && fq[j].size() != 0) begin
            any = 1;
            if (g < 0) g = j;
         end
      end
      iss     = (g >= 0) && (!m_pend || rdy);
      exp_ren = '0;
      if (iss && !rst) exp_ren = N'(1 << g);
      o_ren   = src_ren;
      o_valid = out_valid;
      o_src   = out_src;
      o_data  = out_data;
      o_busy  = busy;
      check("model_ren",   64'(o_ren),   64'(exp_ren));
      check("model_valid", 64'(o_valid), 64'(m_pend));
      check("model_src",   64'(o_src),   64'(m_sel));
      check("model_busy",  64'(o_busy),  64'(m_pend || any));
      if (m_pend) check("model_data", 64'(o_data), 64'(m_word));
      if (rst) begin
         m_pend = 0;
         m_sel  = 0;
         m_ptr  = 0;
      end else if (iss) begin
         m_pend = 1;
         m_sel  = g;
         m_ptr  = (g + 1) % N;
         m_word = fq[g][0];
      end else if (m_pend && rdy) begin
         m_pend = 0;
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         if (o_ren[i] && fq[i].size() > 0) rd[i] = fq[i].pop_front();
      end
      for (int i = 0; i < N; i++) begin
         if (push[i]) load(i, 1);
      end
      drive_env();
   endtask

   logic [W-1:0] held;

   initial begin
      // Fairness table: counts {2,2,2,2}, all enabled, consumer always ready.
      tbl[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
      tbl[1] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
      tbl[2] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
      tbl[3] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1};
      tbl[4] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1};
      tbl[5] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
      tbl[6] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
      tbl[7] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1};
      tbl[8] = '{4'hF, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
      tbl[9] = '{4'hF, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};

      for (int i = 0; i < N; i++) rd[i] = '0;
      m_pend = 0; m_sel = 0; m_ptr = 0; m_word = '0;
      src_enable = '0;
      out_ready  = 1'b0;
      reset      = 1'b1;
      drive_env();

      // Reset with all counts at 3; first edge only brings registers out of X.
      for (int i = 0; i < N; i++) load(i, 3);
      @(posedge clock);
      #1;
      for (int r = 0; r < 2; r++) begin
         cycle(4'hF, 1'b1, 1'b1, '0);
         check("rst_ren",   64'(o_ren),   64'(0));
         check("rst_valid", 64'(o_valid), 64'(0));
         check("rst_src",   64'(o_src),   64'(0));
      end
      cycle(4'hF, 1'b1, 1'b0, '0);
      check("first_grant", 64'(o_ren), 64'(4'b0001));
      cycle(4'h0, 1'b1, 1'b0, '0);
      cycle(4'h0, 1'b1, 1'b0, '0);
      for (int i = 0; i < N; i++) fq[i].delete();
      cycle(4'h0, 1'b0, 1'b1, '0);

      // Table-driven fairness run
      for (int i = 0; i < N; i++) load(i, 2);
      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].en, tbl[i].rdy, 1'b0, '0);
         check($sformatf("tbl%0d_ren", i),   64'(o_ren),   64'(tbl[i].exp_ren));
         check($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'(tbl[i].exp_valid));
         check($sformatf("tbl%0d_src", i),   64'(o_src),   64'(tbl[i].exp_src));
         check($sformatf("tbl%0d_busy", i),  64'(o_busy),  64'(tbl[i].exp_busy));
      end

      // Backpressure: word pending from src 2 held for 5 cycles.
      load(2, 2);
      cycle(4'hF, 1'b0, 1'b0, '0);
      check("bp_grant2", 64'(o_ren), 64'(4'b0100));
      load(0, 1);
      held = rd[2];
      for (int i = 0; i < 5; i++) begin
         cycle(4'hF, 1'b0, 1'b0, '0);
         check("bp_ren",   64'(o_ren),   64'(0));
         check("bp_valid", 64'(o_valid), 64'(1));
         check("bp_src",   64'(o_src),   64'(2));
         check("bp_data",  64'(o_data),  64'(held));
      end
      cycle(4'hF, 1'b1, 1'b0, '0);
      check("bp_release_ren", 64'(o_ren), 64'(4'b0001));
      cycle(4'hF, 1'b1, 1'b0, '0);
      check("bp_next_ren", 64'(o_ren), 64'(4'b0100));
      cycle(4'hF, 1'b1, 1'b0, '0);
      cycle(4'hF, 1'b1, 1'b0, '0);
      check("bp_drained", 64'(o_valid), 64'(0));

      // Wrap and skip: ptr=3, only src 1 eligible.
      load(1, 1);
      cycle(4'hF, 1'b1, 1'b0, '0);
      check("wrap_grant1", 64'(o_ren), 64'(4'b0010));
      load(2, 1); load(3, 1); load(0, 1);
      cycle(4'hF, 1'b1, 1'b0, '0);
      check("wrap_ptr2", 64'(o_ren), 64'(4'b0100));
      cycle(4'hF, 1'b1, 1'b0, '0);
      check("wrap_grant3", 64'(o_ren), 64'(4'b1000));
      cycle(4'hF, 1'b1, 1'b0, '0);
      check("wrap_grant0", 64'(o_ren), 64'(4'b0001));
      cycle(4'hF, 1'b1, 1'b0, '0);
      cycle(4'hF, 1'b1, 1'b0, '0);

      // Enable mask and count edge on src 0; disabled sources hold data.
      load(0, 1); load(1, 2); load(3, 2);
      cycle(4'b0001, 1'b1, 1'b0, '0);
      check("mask_one_grant", 64'(o_ren), 64'(4'b0001));
      cycle(4'b0001, 1'b0, 1'b0, '0);
      check("mask_no_reread", 64'(o_ren), 64'(0));
      cycle(4'b0000, 1'b0, 1'b0, '0);
      check("mask_pend_valid", 64'(o_valid), 64'(1));
      cycle(4'b0000, 1'b1, 1'b0, '0);
      check("mask_deliver_src", 64'(o_src), 64'(0));
      check("mask_deliver_vld", 64'(o_valid), 64'(1));
      cycle(4'b0000, 1'b1, 1'b0, '0);
      check("mask_idle_busy", 64'(o_busy), 64'(0));
      check("mask_idle_ren",  64'(o_ren),  64'(0));

      // Mid-operation reset while a word is stalled.
      cycle(4'hF, 1'b0, 1'b0, '0);
      cycle(4'hF, 1'b0, 1'b0, '0);
      check("mr_pending", 64'(o_valid), 64'(1));
      cycle(4'hF, 1'b0, 1'b1, '0);
      check("mr_ren_in_rst", 64'(o_ren), 64'(0));
      cycle(4'hF, 1'b0, 1'b0, '0);
      check("mr_valid_clr", 64'(o_valid), 64'(0));
      check("mr_ptr_zero",  64'(o_ren),   64'(4'b0010));
      for (int i = 0; i < 6; i++) cycle(4'hF, 1'b1, 1'b0, '0);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] en;
         logic [N-1:0] push;
         logic         rdy;
         en   = N'($urandom);
         if ($urandom_range(0, 7) == 0) en = '1;
         rdy  = ($urandom_range(0, 3) != 0);
         push = N'($urandom) & N'($urandom);
         cycle(en, rdy, 1'b0, push);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
